key_event_decoder: RTL
======================

# key_event_decoder

Classifies presses of one debounced, active-low push button and emits single-cycle event pulses: click, double-click, long-press and auto-repeat. It sits directly downstream of the key debouncer and consumes its `deb_key_n` output. Its pulses feed control and menu logic, so downstream blocks never time key presses themselves.

## Interface
- `LONG_CYCLES`, default 50_000_000: hold time, in clocks, that turns a press into a long-press (1 s at 50 MHz).
- `DCLICK_CYCLES`, default 12_500_000: window after a short release in which a second press counts as a double-click.
- `REPEAT_CYCLES`, default 5_000_000: auto-repeat period while a long-press is held.
- `WIDTH`, default `$clog2(LONG_CYCLES+1)`: counter width.
- Parameter rules: all three cycle counts are ≥ 2, and DCLICK_CYCLES and REPEAT_CYCLES are each ≤ LONG_CYCLES.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `deb_key_n`  in  1  debounced key; 0 = pressed. Already synchronous to `clk`.
- `click_o`  out  1  one-cycle pulse: a single short press completed.
- `dclick_o`  out  1  one-cycle pulse: a double-click was detected.
- `long_o`  out  1  one-cycle pulse: the press was held for LONG_CYCLES.
- `repeat_o`  out  1  one-cycle pulse every REPEAT_CYCLES while the long-press continues.
- `key_held_o`  out  1  level: high while in PRESS1, LONG or HOLD2.

## Operation
- Edge detection:
  - `k_r` is a register of `deb_key_n`; its reset value is 1.
  - `press_e = k_r & ~deb_key_n`.
  - `rel_e = ~k_r & deb_key_n`.
- A single counter `cnt` (WIDTH bits) is cleared to 0 on every state transition and increments in the timed states PRESS1, WAIT2 and LONG.
- FSM states: IDLE, PRESS1, WAIT2, HOLD2, LONG. Reset state is IDLE.
- Transitions:
  - IDLE: on `press_e`, go to PRESS1.
  - PRESS1, release wins: on `rel_e`, go to WAIT2. This takes priority over the terminal count in the same cycle.
  - PRESS1, long-press: when `cnt == LONG_CYCLES-1` and the key is still held, go to LONG and pulse `long_o`.
  - WAIT2, second press wins: on `press_e`, go to HOLD2 and pulse `dclick_o`. This takes priority over window expiry in the same cycle.
  - WAIT2, window expiry: when `cnt == DCLICK_CYCLES-1`, go to IDLE and pulse `click_o`.
  - HOLD2: on `rel_e`, go to IDLE. There is no long or repeat detection in HOLD2.
  - LONG, release wins: on `rel_e`, go to IDLE. This takes priority over the repeat terminal count. No click is emitted.
  - LONG, repeat: when `cnt == REPEAT_CYCLES-1`, pulse `repeat_o`, clear `cnt` and stay in LONG.
- Only one event pulse can be high in any cycle. Every press produces exactly one of: click, dclick or long (plus any repeats).
- A key already held low when reset releases is seen as `press_e` on the first clock edge and enters PRESS1.

## Timing
- Reset (asynchronous, any state, including mid-press or mid-repeat):
  - All outputs go to 0.
  - `k_r` = 1, `cnt` = 0, state = IDLE.
- All outputs are registered. A pulse is set on the same clock edge as its state transition and is high for exactly the one following cycle.
- Latencies, with edge P = press-detect edge and R = release-detect edge:
  - `long_o` goes high after edge P+LONG_CYCLES.
  - `repeat_o` goes high after edges P+LONG_CYCLES+k·REPEAT_CYCLES, for k = 1, 2, …
  - `click_o` goes high after edge R+DCLICK_CYCLES.
  - `dclick_o` goes high after the second press-detect edge.
- `key_held_o` rises and falls on the same edge as the corresponding state change.
- The counter never wraps. Every terminal compare fires at or below LONG_CYCLES-1, which fits in WIDTH bits.

## Test plan
All scenarios use LONG_CYCLES=20, DCLICK_CYCLES=8, REPEAT_CYCLES=5.

- Short click: press for 5 cycles, then release and stay idle → one `click_o` pulse 8 edges after the release edge. No other pulses. `key_held_o` is high for 5 cycles.
- Double-click: press 5, release 3, press 4, release → one `dclick_o` pulse on the second press edge. No `click_o` at any point, including after the final release.
- Long with repeat: hold for 32 cycles → `long_o` at P+20, `repeat_o` at P+25 and P+30. After release, the state is IDLE and no `click_o` follows.
- Long/release collision: release so that `rel_e` lands exactly on the cycle with `cnt==19` → no `long_o`; `click_o` follows 8 edges later.
- Dclick/expiry collision: second `press_e` on the cycle with WAIT2 `cnt==7` → `dclick_o` only, no `click_o`.
- Reset mid-LONG: assert `rst_n` low between repeats while the key stays held → all outputs drop to 0 immediately. After `rst_n` deasserts, the first edge enters PRESS1, and `long_o` fires 20 edges later.

Source files
------------

// File: rtl/key_event_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : key_event_decoder_if
// Purpose  : Bundles the debounced key input and the classified key-event
//            outputs of key_event_decoder into one interface.
// Signals  : deb_key_n  - debounced key, 0 = pressed (driven by upstream)
//            click_o    - one-cycle pulse, single short press completed
//            dclick_o   - one-cycle pulse, double-click detected
//            long_o     - one-cycle pulse, long-press threshold reached
//            repeat_o   - one-cycle pulse, auto-repeat while long-press held
//            key_held_o - level, key is held in a press state
// Modports : master - upstream/consumer side (drives the key, reads events)
//            slave  - decoder side (reads the key, drives events)
// Revision : 1.0 - initial release
// ============================================================================
interface key_event_decoder_if;
    logic deb_key_n;
    logic click_o;
    logic dclick_o;
    logic long_o;
    logic repeat_o;
    logic key_held_o;

    modport master (
        output deb_key_n,
        input  click_o,
        input  dclick_o,
        input  long_o,
        input  repeat_o,
        input  key_held_o
    );

    modport slave (
        input  deb_key_n,
        output click_o,
        output dclick_o,
        output long_o,
        output repeat_o,
        output key_held_o
    );
endinterface
`default_nettype wire

// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : key_event_decoder
// Purpose  : Classifies presses of one debounced active-low push button into
//            single-cycle event pulses: click, double-click, long-press and
//            auto-repeat. All outputs are registered.
// Ports    : clk   - system clock
//            rst_n - asynchronous active-low reset
//            bus   - key_event_decoder_if.slave (deb_key_n in; click_o,
//                    dclick_o, long_o, repeat_o, key_held_o out)
// Params   : LONG_CYCLES   - hold time that makes a press a long-press
//            DCLICK_CYCLES - window after a short release for a 2nd press
//            REPEAT_CYCLES - auto-repeat period during a long-press
//            WIDTH         - counter width
//            All cycle counts >= 2; DCLICK_CYCLES, REPEAT_CYCLES <= LONG_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_decoder #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DCLICK_CYCLES = 12_500_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int WIDTH         = $clog2(LONG_CYCLES + 1)
) (
    input  wire                    clk,
    input  wire                    rst_n,
    key_event_decoder_if.slave     bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_WAIT2  = 3'd2,
        S_HOLD2  = 3'd3,
        S_LONG   = 3'd4
    } state_t;

    // Terminal counts; all are <= LONG_CYCLES-1 so the counter never wraps.
    localparam logic [WIDTH-1:0] C_LONG_TC   = WIDTH'(LONG_CYCLES - 1);
    localparam logic [WIDTH-1:0] C_DCLICK_TC = WIDTH'(DCLICK_CYCLES - 1);
    localparam logic [WIDTH-1:0] C_REPEAT_TC = WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [WIDTH-1:0] C_ONE       = WIDTH'(1);

    state_t           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic             k_q;
    logic             click_q;
    logic             dclick_q;
    logic             long_q;
    logic             repeat_q;
    logic             held_q;

    logic             press_e;
    logic             rel_e;

    // k_q resets to 1, so a key already low at reset release reads as a press.
    assign press_e = k_q & ~bus.deb_key_n;
    assign rel_e   = ~k_q & bus.deb_key_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            k_q      <= 1'b1;
            click_q  <= 1'b0;
            dclick_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            k_q      <= bus.deb_key_n;
            // Pulses are high for exactly one cycle after their transition.
            click_q  <= 1'b0;
            dclick_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (press_e) begin
                        state_q <= S_PRESS1;
                        cnt_q   <= '0;
                        held_q  <= 1'b1;
                    end
                end

                S_PRESS1: begin
                    // Release takes priority over the long terminal count.
                    if (rel_e) begin
                        state_q <= S_WAIT2;
                        cnt_q   <= '0;
                        held_q  <= 1'b0;
                    end else if (cnt_q == C_LONG_TC) begin
                        state_q <= S_LONG;
                        cnt_q   <= '0;
                        long_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + C_ONE;
                    end
                end

                S_WAIT2: begin
                    // A second press takes priority over window expiry.
                    if (press_e) begin
                        state_q  <= S_HOLD2;
                        cnt_q    <= '0;
                        dclick_q <= 1'b1;
                        held_q   <= 1'b1;
                    end else if (cnt_q == C_DCLICK_TC) begin
                        state_q  <= S_IDLE;
                        cnt_q    <= '0;
                        click_q  <= 1'b1;
                    end else begin
                        cnt_q    <= cnt_q + C_ONE;
                    end
                end

                S_HOLD2: begin
                    // Second press of a double-click is never timed.
                    if (rel_e) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        held_q  <= 1'b0;
                    end
                end

                S_LONG: begin
                    // Release ends the long-press silently, even on a repeat tick.
                    if (rel_e) begin
                        state_q  <= S_IDLE;
                        cnt_q    <= '0;
                        held_q   <= 1'b0;
                    end else if (cnt_q == C_REPEAT_TC) begin
                        cnt_q    <= '0;
                        repeat_q <= 1'b1;
                    end else begin
                        cnt_q    <= cnt_q + C_ONE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.click_o    = click_q;
    assign bus.dclick_o   = dclick_q;
    assign bus.long_o     = long_q;
    assign bus.repeat_o   = repeat_q;
    assign bus.key_held_o = held_q;

endmodule
`default_nettype wire
